sdf_bf2_stage: RTL and testbench

- Generalised radix-2 single-delay-feedback (SDF) butterfly stage, the next generation of the team's SDF units.
- Parametrised data width and delay depth; optional trivial ±j rotation (radix-2² BF2II behaviour); optional 1-bit scaling; frame resync via di_sof.
- One instance per FFT stage, chained do_* -> di_* between stages.

---
 rtl/sdf_bf2_stage_pkg.sv | 23 ++
 rtl/sdf_bf2_stage_delay_line.sv | 52 +++++
 rtl/sdf_bf2_stage.sv | 130 +++++++++++++
 tb/tb_sdf_bf2_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sdf_bf2_stage_pkg.sv
// Shared definitions for the SDF butterfly stage: default width,
// a constant log2 helper and the delay-line entry field layout.
package sdf_bf2_stage_pkg;

  localparam int DEF_DATA_W = 16;

  // Entry layout, LSB first: inv, rot, valid, then im, then re.
  localparam int FLAG_W    = 3;
  localparam int INV_BIT   = 0;
  localparam int ROT_BIT   = 1;
  localparam int VALID_BIT = 2;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdf_bf2_stage_delay_line.sv
// Depth-DEPTH shift register of WIDTH-bit entries. Only the per-entry
// valid bit is reset; flush clears the valid bits of the entries already
// stored while the incoming entry is still written unchanged.
module sdf_delay_line #(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 8,
  parameter int VALID_POS = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             shift_en,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] data_reg [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [WIDTH-1:0] data_next [DEPTH];
  logic [DEPTH-1:0] valid_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_tap
      if (gi == 0) begin : g_first
        assign data_next[gi]  = din;
        assign valid_next[gi] = din[VALID_POS];
      end else begin : g_rest
        assign data_next[gi]  = data_reg[gi-1];
        assign valid_next[gi] = valid_reg[gi-1] & ~flush;
      end

      // Payload storage; contents are don't-care until their valid bit is set.
      always_ff @(posedge clk) begin
        if (shift_en) data_reg[gi] <= data_next[gi];
      end

      // Valid bit of this tap, cleared by reset.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         valid_reg[gi] <= 1'b0;
        else if (shift_en) valid_reg[gi] <= valid_next[gi];
      end
    end
  endgenerate

  // Head entry with its live valid bit merged in.
  always_comb begin
    dout            = data_reg[DEPTH-1];
    dout[VALID_POS] = valid_reg[DEPTH-1];
  end

endmodule

// File: rtl/sdf_bf2_stage.sv
// Radix-2 single-delay-feedback butterfly stage with optional trivial
// +-j rotation of late differences, optional 1-bit output scaling and
// frame resynchronisation on di_sof.
module sdf_bf2_stage
  import sdf_bf2_stage_pkg::*;
#(
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int DELAY_DEPTH = 4,
  parameter  int ROT_EN      = 0,
  parameter  int SCALE       = 0,
  localparam int OUT_W       = DATA_W + 1 - SCALE
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              di_en,
  input  logic              di_sof,
  input  logic              di_inv,
  input  logic [DATA_W-1:0] di_re,
  input  logic [DATA_W-1:0] di_im,
  output logic              do_en,
  output logic              do_sof,
  output logic [OUT_W-1:0]  do_re,
  output logic [OUT_W-1:0]  do_im
);

  localparam int SW      = DATA_W + 1;
  localparam int ENTRY_W = 2 * SW + FLAG_W;
  localparam int CW      = clog2_f(4 * DELAY_DEPTH);
  localparam int LD      = clog2_f(DELAY_DEPTH);
  localparam int RE_LSB  = FLAG_W + SW;
  localparam int IM_LSB  = FLAG_W;

  logic [CW-1:0]      cnt_reg;
  logic [CW-1:0]      cnt_eff;
  logic               sof_acc;
  logic               phase_b;
  logic               late_quarter;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic signed [SW-1:0] x_re, x_im, y_re, y_im;
  logic signed [SW-1:0] cand_re, cand_im;
  logic               y_valid, y_rot, y_inv;
  logic [OUT_W-1:0]   out_re, out_im;

  // A qualified sof restarts the frame at index 0 for the current sample.
  assign sof_acc      = di_en & di_sof;
  assign cnt_eff      = sof_acc ? '0 : cnt_reg;
  assign phase_b      = cnt_eff[LD];
  assign late_quarter = cnt_eff[LD+1] & cnt_eff[LD];

  assign x_re = {di_re[DATA_W-1], di_re};
  assign x_im = {di_im[DATA_W-1], di_im};

  assign y_re    = head_entry[RE_LSB +: SW];
  assign y_im    = head_entry[IM_LSB +: SW];
  assign y_valid = head_entry[VALID_BIT] & ~sof_acc;
  assign y_rot   = head_entry[ROT_BIT];
  assign y_inv   = head_entry[INV_BIT];

  sdf_delay_line #(
    .DEPTH     (DELAY_DEPTH),
    .WIDTH     (ENTRY_W),
    .VALID_POS (VALID_BIT)
  ) u_delay (
    .clk      (clk),
    .rstn     (rstn),
    .shift_en (di_en),
    .flush    (sof_acc),
    .din      (push_entry),
    .dout     (head_entry)
  );

  // Butterfly: phase A stores inputs and drains differences, phase B
  // emits sums and stores differences (tagged for rotation when late).
  always_comb begin
    push_entry = '0;
    cand_re    = y_re;
    cand_im    = y_im;
    if (!phase_b) begin
      push_entry[RE_LSB +: SW] = x_re;
      push_entry[IM_LSB +: SW] = x_im;
      push_entry[VALID_BIT]    = 1'b1;
      push_entry[INV_BIT]      = di_inv;
      if (y_rot) begin
        if (y_inv) begin
          cand_re = -y_im;
          cand_im = y_re;
        end else begin
          cand_re = y_im;
          cand_im = -y_re;
        end
      end
    end else begin
      push_entry[RE_LSB +: SW] = y_re - x_re;
      push_entry[IM_LSB +: SW] = y_im - x_im;
      push_entry[VALID_BIT]    = y_valid;
      push_entry[ROT_BIT]      = (ROT_EN != 0) & late_quarter;
      push_entry[INV_BIT]      = di_inv;
      cand_re = y_re + x_re;
      cand_im = y_im + x_im;
    end
  end

  // Optional floor halving; the shift amount is 0 when scaling is off.
  assign out_re = OUT_W'(cand_re >>> SCALE);
  assign out_im = OUT_W'(cand_im >>> SCALE);

  // Sample counter and output registers, advanced only on accepted samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
      do_en   <= 1'b0;
      do_sof  <= 1'b0;
      do_re   <= '0;
      do_im   <= '0;
    end else if (di_en) begin
      cnt_reg <= cnt_eff + CW'(1);
      do_en   <= y_valid;
      do_sof  <= y_valid & (cnt_eff == CW'(DELAY_DEPTH));
      if (y_valid) begin
        do_re <= out_re;
        do_im <= out_im;
      end
    end else begin
      do_en  <= 1'b0;
      do_sof <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdf_bf2_stage.sv
// Directed bench for sdf_bf2_stage: four instances share one stimulus
// stream (plain, rotating, scaling, D=4); each step checks the relevant one.
module tb_sdf_bf2_stage;

  logic clk = 1'b0;
  logic rstn;
  logic di_en, di_sof, di_inv;
  logic [7:0] di_re, di_im;

  logic a_en, a_sof, r_en, r_sof, s_en, s_sof, d_en, d_sof;
  logic signed [8:0] a_re, a_im, r_re, r_im, d_re, d_im;
  logic signed [7:0] s_re, s_im;

  int checks   = 0;
  int failures = 0;

  // Expected outputs per sample index of a sof-started ramp (D=1).
  int exp_en [9]  = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
  int exp_a_re[9] = '{0, 1, -1, 5, -1, 9, -1, 13, -1};
  int exp_r_re[9] = '{0, 1, -1, 5, 0, 9, -1, 13, 0};
  int exp_r_im[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
  int exp_ri_im[9] = '{0, 0, 0, 0, -1, 0, 0, 0, -1};

  always #5 clk = ~clk;

  sdf_bf2_stage #(.DATA_W(8), .DELAY_DEPTH(1), .ROT_EN(0), .SCALE(0)) dut_a (
    .clk(clk), .rstn(rstn), .di_en(di_en), .di_sof(di_sof), .di_inv(di_inv),
    .di_re(di_re), .di_im(di_im), .do_en(a_en), .do_sof(a_sof), .do_re(a_re), .do_im(a_im));

  sdf_bf2_stage #(.DATA_W(8), .DELAY_DEPTH(1), .ROT_EN(1), .SCALE(0)) dut_r (
    .clk(clk), .rstn(rstn), .di_en(di_en), .di_sof(di_sof), .di_inv(di_inv),
    .di_re(di_re), .di_im(di_im), .do_en(r_en), .do_sof(r_sof), .do_re(r_re), .do_im(r_im));

  sdf_bf2_stage #(.DATA_W(8), .DELAY_DEPTH(1), .ROT_EN(0), .SCALE(1)) dut_s (
    .clk(clk), .rstn(rstn), .di_en(di_en), .di_sof(di_sof), .di_inv(di_inv),
    .di_re(di_re), .di_im(di_im), .do_en(s_en), .do_sof(s_sof), .do_re(s_re), .do_im(s_im));

  sdf_bf2_stage #(.DATA_W(8), .DELAY_DEPTH(4), .ROT_EN(0), .SCALE(0)) dut_d (
    .clk(clk), .rstn(rstn), .di_en(di_en), .di_sof(di_sof), .di_inv(di_inv),
    .di_re(di_re), .di_im(di_im), .do_en(d_en), .do_sof(d_sof), .do_re(d_re), .do_im(d_im));

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
  task automatic send(input bit en, input bit sof, input bit inv, input int re, input int im);
    di_en  = en;
    di_sof = sof;
    di_inv = inv;
    di_re  = re[7:0];
    di_im  = im[7:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; di_en = 0; di_sof = 0; di_inv = 0; di_re = '0; di_im = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a_en", a_en, 0);
    chk("reset_a_sof", a_sof, 0);
    chk("reset_a_re", a_re, 0);
    chk("reset_a_im", a_im, 0);
    chk("reset_d_en", d_en, 0);
    rstn = 1'b1;

    // Continuous ramp, -j rotation.
    for (int i = 0; i < 9; i++) begin
      send(1, i == 0, 0, i, 0);
      $display("ramp   i=%0d a_en=%0d a=(%0d,%0d) r=(%0d,%0d) sof=%0d", i, a_en, a_re, a_im, r_re, r_im, a_sof);
      chk($sformatf("ramp_a_en[%0d]", i), a_en, exp_en[i]);
      chk($sformatf("ramp_r_en[%0d]", i), r_en, exp_en[i]);
      if (i > 0) begin
        chk($sformatf("ramp_a_re[%0d]", i), a_re, exp_a_re[i]);
        chk($sformatf("ramp_a_im[%0d]", i), a_im, 0);
        chk($sformatf("ramp_r_re[%0d]", i), r_re, exp_r_re[i]);
        chk($sformatf("ramp_r_im[%0d]", i), r_im, exp_r_im[i]);
      end
      if (i >= 1 && i <= 4) chk($sformatf("ramp_a_sof[%0d]", i), a_sof, (i == 1) ? 1 : 0);
    end

    // Same ramp in inverse mode: rotated entries use +j.
    for (int i = 0; i < 9; i++) begin
      send(1, i == 0, 1, i, 0);
      $display("inv    i=%0d r_en=%0d r=(%0d,%0d)", i, r_en, r_re, r_im);
      chk($sformatf("inv_r_en[%0d]", i), r_en, exp_en[i]);
      if (i > 0) begin
        chk($sformatf("inv_r_re[%0d]", i), r_re, exp_r_re[i]);
        chk($sformatf("inv_r_im[%0d]", i), r_im, exp_ri_im[i]);
      end
    end

    // Gapped input; idle cycles carry junk data and an unqualified sof.
    for (int i = 0; i < 9; i++) begin
      send(1, i == 0, 0, i, 0);
      $display("gap    i=%0d a_en=%0d a_re=%0d", i, a_en, a_re);
      chk($sformatf("gap_a_en[%0d]", i), a_en, exp_en[i]);
      if (i > 0) chk($sformatf("gap_a_re[%0d]", i), a_re, exp_a_re[i]);
      send(0, 1, 0, 99, 99);
      chk($sformatf("gap_idle_en[%0d]", i), a_en, 0);
      if (i > 0) chk($sformatf("gap_hold_re[%0d]", i), a_re, exp_a_re[i]);
    end

    // Scaling corners.
    send(1, 1, 0, 127, 0);
    chk("scale_first_en", s_en, 0);
    send(1, 0, 0, 127, 0);
    $display("scale  127+127 -> %0d", s_re);
    chk("scale_max_en", s_en, 1);
    chk("scale_max_re", s_re, 127);
    send(1, 1, 0, -128, 0);
    chk("scale_sof_en", s_en, 0);
    send(1, 0, 0, -128, 0);
    $display("scale  -128-128 -> %0d", s_re);
    chk("scale_min_re", s_re, -128);
    send(1, 1, 0, 127, 0);
    send(1, 0, 0, -128, 0);
    $display("scale  127-128 sum -> %0d", s_re);
    chk("scale_mix_sum", s_re, -1);
    send(1, 0, 0, 0, 0);
    $display("scale  127-128 diff -> %0d", s_re);
    chk("scale_mix_diff_en", s_en, 1);
    chk("scale_mix_diff", s_re, 127);
    chk("scale_mix_im", s_im, 0);

    // D=4: resync in mid-frame at sample 6.
    for (int i = 0; i < 12; i++) begin
      send(1, (i == 0) || (i == 6), 0, i, 0);
      $display("d4     i=%0d d_en=%0d d_re=%0d d_sof=%0d", i, d_en, d_re, d_sof);
      chk($sformatf("d4_en[%0d]", i), d_en, (i == 4 || i == 5 || i == 10 || i == 11) ? 1 : 0);
      if (i == 4)  chk("d4_re[4]", d_re, 4);
      if (i == 5)  chk("d4_re[5]", d_re, 6);
      if (i == 10) begin
        chk("d4_re[10]", d_re, 16);
        chk("d4_sof[10]", d_sof, 1);
      end
      if (i == 11) begin
        chk("d4_re[11]", d_re, 18);
        chk("d4_sof[11]", d_sof, 0);
      end
    end

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) send(1, i == 0, 0, i, 0);
    chk("pre_rst_en", a_en, 1);
    chk("pre_rst_re", a_re, -1);
    #2 rstn = 1'b0;
    #1;
    $display("arst   a_en=%0d a_sof=%0d a=(%0d,%0d)", a_en, a_sof, a_re, a_im);
    chk("arst_en", a_en, 0);
    chk("arst_sof", a_sof, 0);
    chk("arst_re", a_re, 0);
    chk("arst_im", a_im, 0);
    @(posedge clk);
    #3 rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1, 0, 0, i, 0);
      $display("post   i=%0d a_en=%0d a_re=%0d a_sof=%0d", i, a_en, a_re, a_sof);
      chk($sformatf("post_en[%0d]", i), a_en, exp_en[i]);
      if (i > 0) chk($sformatf("post_re[%0d]", i), a_re, exp_a_re[i]);
      if (i == 1) chk("post_sof[1]", a_sof, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
